// File: rtl/egg_drop_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : egg_drop_ctrl
//  Description : Game-level initiator for the egg animator. Paces frames,
//                issues a one-cycle go per frame, tracks the falling egg,
//                spawns eggs at LFSR-derived x, keeps score/lives/speed and
//                declares game over.
//  Revision    : 1.0 - initial release
// ============================================================================
module egg_drop_ctrl #(
    parameter int         SCREEN_W   = 160,
    parameter logic [6:0] SPAWN_Y    = 7'd0,
    parameter logic [6:0] CATCH_Y    = 7'd120,
    parameter logic [1:0] LIVES_INIT = 2'd3,
    parameter int         LEVEL_STEP = 4,
    parameter logic [2:0] MAX_SPEED  = 3'd7,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       frame_tick,
    input  logic       anim_done,
    input  logic       anim_lose,
    input  logic [6:0] anim_out_y,
    output logic       go,
    output logic [7:0] egg_x,
    output logic [6:0] egg_y,
    output logic [2:0] speed,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic       busy,
    output logic       game_over
);

    localparam int              CNT_W        = $clog2(LEVEL_STEP + 1);
    localparam logic [CNT_W-1:0] c_CNT_STEP  = CNT_W'(LEVEL_STEP);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [7:0]      c_SCREEN_W   = 8'(SCREEN_W);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_SPAWN     = 3'd1;
    localparam logic [2:0] c_ST_WAIT_TICK = 3'd2;
    localparam logic [2:0] c_ST_ISSUE     = 3'd3;
    localparam logic [2:0] c_ST_WAIT_ANIM = 3'd4;
    localparam logic [2:0] c_ST_SCORE     = 3'd5;
    localparam logic [2:0] c_ST_GAME_OVER = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [7:0]       lfsr_q;
    logic             go_q, go_d;
    logic             busy_q, busy_d;
    logic [7:0]       egg_x_q, egg_x_d;
    logic [6:0]       egg_y_q, egg_y_d;
    logic [2:0]       speed_q, speed_d;
    logic [7:0]       score_q, score_d;
    logic [1:0]       lives_q, lives_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             w_lfsr_fb;
    logic [7:0]       w_spawn_x;
    logic [CNT_W-1:0] w_cnt_inc;

    // Fibonacci taps 8,6,5,4; spawn x folds the LFSR value into [0, SCREEN_W)
    always_comb begin
        w_lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
        w_spawn_x = (lfsr_q < c_SCREEN_W) ? lfsr_q : (lfsr_q - c_SCREEN_W);
        w_cnt_inc = cnt_q + c_CNT_ONE;
    end

    // Game sequencing: next state and next values of all game registers
    always_comb begin
        state_d = state_q;
        go_d    = 1'b0;
        busy_d  = busy_q;
        egg_x_d = egg_x_q;
        egg_y_d = egg_y_q;
        speed_d = speed_q;
        score_d = score_q;
        lives_d = lives_q;
        cnt_d   = cnt_q;
        case (state_q)
            c_ST_IDLE, c_ST_GAME_OVER: begin
                if (start) begin
                    state_d = c_ST_SPAWN;
                    score_d = 8'd0;
                    lives_d = LIVES_INIT;
                    speed_d = 3'd1;
                    cnt_d   = '0;
                end
            end
            c_ST_SPAWN: begin
                egg_x_d = w_spawn_x;
                egg_y_d = SPAWN_Y;
                state_d = c_ST_WAIT_TICK;
            end
            c_ST_WAIT_TICK: begin
                if (frame_tick) begin
                    state_d = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                // go and busy are registered, so they rise as WAIT_ANIM begins
                go_d    = 1'b1;
                busy_d  = 1'b1;
                state_d = c_ST_WAIT_ANIM;
            end
            c_ST_WAIT_ANIM: begin
                // A miss outranks a simultaneous done; ticks here are dropped
                if (anim_lose) begin
                    busy_d  = 1'b0;
                    lives_d = lives_q - 2'd1;
                    state_d = (lives_q == 2'd1) ? c_ST_GAME_OVER : c_ST_SPAWN;
                end else if (anim_done) begin
                    busy_d = 1'b0;
                    if (anim_out_y >= CATCH_Y) begin
                        state_d = c_ST_SCORE;
                    end else begin
                        egg_y_d = anim_out_y;
                        state_d = c_ST_WAIT_TICK;
                    end
                end
            end
            c_ST_SCORE: begin
                score_d = (score_q == 8'hFF) ? score_q : (score_q + 8'd1);
                if (w_cnt_inc == c_CNT_STEP) begin
                    cnt_d   = '0;
                    speed_d = (speed_q < MAX_SPEED) ? (speed_q + 3'd1) : MAX_SPEED;
                end else begin
                    cnt_d = w_cnt_inc;
                end
                state_d = c_ST_SPAWN;
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    // State and game registers; the LFSR free-runs outside reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= c_ST_IDLE;
            lfsr_q  <= LFSR_SEED;
            go_q    <= 1'b0;
            busy_q  <= 1'b0;
            egg_x_q <= 8'd0;
            egg_y_q <= SPAWN_Y;
            speed_q <= 3'd1;
            score_q <= 8'd0;
            lives_q <= LIVES_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= {lfsr_q[6:0], w_lfsr_fb};
            go_q    <= go_d;
            busy_q  <= busy_d;
            egg_x_q <= egg_x_d;
            egg_y_q <= egg_y_d;
            speed_q <= speed_d;
            score_q <= score_d;
            lives_q <= lives_d;
            cnt_q   <= cnt_d;
        end
    end

    assign go        = go_q;
    assign busy      = busy_q;
    assign egg_x     = egg_x_q;
    assign egg_y     = egg_y_q;
    assign speed     = speed_q;
    assign score     = score_q;
    assign lives     = lives_q;
    assign game_over = (state_q == c_ST_GAME_OVER);

endmodule
`default_nettype wire

// File: tb/tb_egg_drop_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_egg_drop_ctrl
//  Description : Randomised scoreboard bench for egg_drop_ctrl. Stimulus acts
//                as frame divider and animator; a game-level model predicts
//                the values presented with each go.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_egg_drop_ctrl;

    localparam int SCREEN_W   = 160;
    localparam int SPAWN_Y    = 0;
    localparam int LIVES_INIT = 3;
    localparam int LEVEL_STEP = 4;
    localparam int MAX_SPEED  = 7;
    localparam logic [7:0] LFSR_SEED = 8'hA5;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       start      = 1'b0;
    logic       frame_tick = 1'b0;
    logic       anim_done  = 1'b0;
    logic       anim_lose  = 1'b0;
    logic [6:0] anim_out_y = 7'd0;
    logic       go, busy, game_over;
    logic [7:0] egg_x, score;
    logic [6:0] egg_y;
    logic [2:0] speed;
    logic [1:0] lives;

    egg_drop_ctrl u_dut (
        .clock      (clk),
        .reset      (rst),
        .start      (start),
        .frame_tick (frame_tick),
        .anim_done  (anim_done),
        .anim_lose  (anim_lose),
        .anim_out_y (anim_out_y),
        .go         (go),
        .egg_x      (egg_x),
        .egg_y      (egg_y),
        .speed      (speed),
        .score      (score),
        .lives      (lives),
        .busy       (busy),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference LFSR: taps 8,6,5,4, shifting toward the MSB
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    logic [7:0] m_lfsr = LFSR_SEED;
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        m_lfsr <= rst ? LFSR_SEED : lfsr_next(m_lfsr);
    end

    // Game-level model
    int m_score, m_lives, m_speed, m_cnt, m_x, m_y;

    typedef struct {
        int c;
        int x;
        int y;
        int sp;
        int sc;
        int lv;
    } exp_t;
    exp_t sbq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Monitor: every go must match the oldest outstanding expectation
    initial begin : monitor
        exp_t e;
        logic prev_go;
        prev_go = 1'b0;
        forever begin
            @(negedge clk);
            if (go === 1'b1) begin
                chk("go_spacing", {31'd0, prev_go}, 0);
                chk("go_expected", (sbq.size() > 0) ? 1 : 0, 1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("go_latency", cyc, e.c);
                    chk("go_egg_x", {24'd0, egg_x}, e.x);
                    chk("go_egg_y", {25'd0, egg_y}, e.y);
                    chk("go_speed", {29'd0, speed}, e.sp);
                    chk("go_score", {24'd0, score}, e.sc);
                    chk("go_lives", {30'd0, lives}, e.lv);
                    chk("go_busy",  {31'd0, busy}, 1);
                end
            end
            prev_go = go;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Called during the cycle the controller sits in SPAWN
    task automatic spawn_now();
        int v;
        v   = m_lfsr;
        m_x = (v < SCREEN_W) ? v : v - SCREEN_W;
        m_y = SPAWN_Y;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start   = 1'b0;
        m_score = 0;
        m_lives = LIVES_INIT;
        m_speed = 1;
        m_cnt   = 0;
        spawn_now();
        step();
    endtask

    // From WAIT_TICK: optional ignored pulses, tick, go, then a wait with ticks
    task automatic issue_frame(input bit noise);
        int n;
        n = noise ? $urandom_range(0, 3) : 0;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                anim_done  = 1'b1;
                anim_lose  = 1'($urandom_range(0, 1));
                anim_out_y = 7'($urandom_range(0, 127));
            end
            step();
            anim_done = 1'b0;
            anim_lose = 1'b0;
        end
        frame_tick = 1'b1;
        sbq.push_back('{c: cyc + 2, x: m_x, y: m_y, sp: m_speed, sc: m_score, lv: m_lives});
        step();
        frame_tick = 1'b0;
        step();
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
            frame_tick = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            step();
            frame_tick = 1'b0;
        end
        chk("busy_before_resp", {31'd0, busy}, 1);
    endtask

    task automatic resp_move(input int y);
        anim_done  = 1'b1;
        anim_out_y = 7'(y);
        step();
        anim_done = 1'b0;
        m_y = y;
        chk("busy_after_move", {31'd0, busy}, 0);
        chk("egg_y_after_move", {25'd0, egg_y}, y);
    endtask

    task automatic resp_catch(input int y);
        anim_done  = 1'b1;
        anim_out_y = 7'(y);
        step();
        anim_done = 1'b0;
        m_score = (m_score < 255) ? m_score + 1 : 255;
        m_cnt++;
        if (m_cnt == LEVEL_STEP) begin
            m_cnt = 0;
            if (m_speed < MAX_SPEED) m_speed++;
        end
        step();
        spawn_now();
        step();
        chk("score_after_catch", {24'd0, score}, m_score);
        chk("speed_after_catch", {29'd0, speed}, m_speed);
        chk("egg_y_after_catch", {25'd0, egg_y}, SPAWN_Y);
    endtask

    task automatic resp_lose(input bit with_done, output bit over);
        int old;
        anim_lose  = 1'b1;
        anim_done  = with_done;
        anim_out_y = 7'd121;
        step();
        anim_lose = 1'b0;
        anim_done = 1'b0;
        old = m_lives;
        m_lives--;
        chk("lives_after_lose", {30'd0, lives}, m_lives);
        chk("score_after_lose", {24'd0, score}, m_score);
        over = (old == 1);
        chk("game_over_after_lose", {31'd0, game_over}, over ? 1 : 0);
        if (!over) begin
            spawn_now();
            step();
        end
    endtask

    task automatic chk_reset();
        chk("rst_go",        {31'd0, go}, 0);
        chk("rst_busy",      {31'd0, busy}, 0);
        chk("rst_game_over", {31'd0, game_over}, 0);
        chk("rst_egg_x",     {24'd0, egg_x}, 0);
        chk("rst_egg_y",     {25'd0, egg_y}, SPAWN_Y);
        chk("rst_speed",     {29'd0, speed}, 1);
        chk("rst_score",     {24'd0, score}, 0);
        chk("rst_lives",     {30'd0, lives}, LIVES_INIT);
    endtask

    task automatic chk_fresh_game();
        chk("new_score",     {24'd0, score}, 0);
        chk("new_lives",     {30'd0, lives}, LIVES_INIT);
        chk("new_speed",     {29'd0, speed}, 1);
        chk("new_game_over", {31'd0, game_over}, 0);
        chk("new_egg_x",     {24'd0, egg_x}, m_x);
        chk("new_egg_y",     {25'd0, egg_y}, SPAWN_Y);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "time limit");
    end

    initial begin : stimulus
        bit over;
        int r;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk_reset();

        // First game: first frame, a move to y=37
        do_start();
        chk_fresh_game();
        chk("spawn_x_range", (egg_x < SCREEN_W) ? 1 : 0, 1);
        issue_frame(1'b1);
        resp_move(37);

        // 24 catches, then enough more to saturate the score
        for (int i = 0; i < 24; i++) begin
            issue_frame(1'(i % 2));
            resp_catch(120 + (i % 8));
        end
        chk("score_24", {24'd0, score}, 24);
        chk("speed_sat", {29'd0, speed}, MAX_SPEED);
        for (int i = 0; i < 240; i++) begin
            issue_frame(1'b0);
            resp_catch($urandom_range(120, 127));
        end
        chk("score_sat", {24'd0, score}, 255);

        // Three misses, the middle one colliding with a done
        issue_frame(1'b1); resp_lose(1'b0, over);
        issue_frame(1'b1); resp_lose(1'b1, over);
        issue_frame(1'b1); resp_lose(1'b0, over);
        chk("game_over_reached", {31'd0, over}, 1);
        repeat (3) begin
            frame_tick = 1'b1;
            anim_done  = 1'b1;
            step();
        end
        frame_tick = 1'b0;
        anim_done  = 1'b0;
        chk("hold_game_over", {31'd0, game_over}, 1);
        chk("hold_lives", {30'd0, lives}, 0);
        chk("hold_score", {24'd0, score}, 255);
        do_start();
        chk_fresh_game();

        // Random play
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            issue_frame(1'b1);
            over = 1'b0;
            if (r < 4)       resp_move($urandom_range(0, 119));
            else if (r < 8)  resp_catch($urandom_range(120, 127));
            else             resp_lose(1'(r == 9), over);
            if (over) begin
                repeat ($urandom_range(0, 3)) step();
                do_start();
                chk_fresh_game();
            end
        end

        // Reset while waiting on the animator, then a stale done
        issue_frame(1'b0);
        rst = 1'b1;
        step();
        rst        = 1'b0;
        anim_done  = 1'b1;
        anim_out_y = 7'd37;
        step();
        anim_done = 1'b0;
        chk_reset();
        repeat (4) begin
            frame_tick = 1'b1;
            step();
        end
        frame_tick = 1'b0;
        step();
        step();
        chk_reset();
        chk("scoreboard_drained", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
